// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   typedef enum logic [2:0] {
      ESPERA_INICIO = 3'd0,
      INICIO        = 3'd1,
      DESPLAZA      = 3'd2,
      RESTA         = 3'd3,
      CORRIGE       = 3'd4,
      FIN           = 3'd5
   } estado_div_t;

   localparam int DIV_N = 8;

   // Quotient reported for a zero divisor at the default width.
   localparam logic [DIV_N-1:0] DIV_CERO_Q = '1;

endpackage

// File: rtl/fsm_div.sv
// Controller for divisor_secuencial: sequences load, N shift/subtract pairs,
// result correction and the one-cycle done state. State is exported for debug.
module fsm_div
   import div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic        count_done_i,
   input  logic        div_zero_i,
   output logic        load_o,
   output logic        shift_o,
   output logic        sub_en_o,
   output logic        count_o,
   output logic        corrige_o,
   output logic        done_o,
   output estado_div_t estado_o
);

   estado_div_t estado_q, estado_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) estado_q <= ESPERA_INICIO;
      else     estado_q <= estado_d;
   end

   always_comb begin
      estado_d = estado_q;
      unique case (estado_q)
         ESPERA_INICIO: if (valid_i) estado_d = INICIO;
         // A zero divisor still passes through CORRIGE, where the
         // divide-by-zero result is written, so done lands one edge later.
         INICIO:        estado_d = div_zero_i ? CORRIGE : DESPLAZA;
         DESPLAZA:      estado_d = RESTA;
         RESTA:         estado_d = count_done_i ? CORRIGE : DESPLAZA;
         CORRIGE:       estado_d = FIN;
         FIN:           estado_d = ESPERA_INICIO;
         default:       estado_d = ESPERA_INICIO;
      endcase
   end

   always_comb begin
      load_o    = 1'b0;
      shift_o   = 1'b0;
      sub_en_o  = 1'b0;
      count_o   = 1'b0;
      corrige_o = 1'b0;
      done_o    = 1'b0;
      unique case (estado_q)
         ESPERA_INICIO: load_o = valid_i;
         DESPLAZA:      shift_o = 1'b1;
         RESTA: begin
            sub_en_o = 1'b1;
            count_o  = 1'b1;
         end
         CORRIGE:       corrige_o = 1'b1;
         FIN:           done_o = 1'b1;
         default:       ;
      endcase
   end

   assign estado_o = estado_q;

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential radix-2 restoring divider, one quotient bit per two cycles.
// Define DIV_SIGNED_EN for two's-complement operands; default is unsigned.
module divisor_secuencial
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid,
   input  logic [N-1:0] dividendo,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] cociente,
   output logic [N-1:0] residuo,
   output logic         div_cero
);

   localparam int CW = $clog2(N + 1);

   logic [N:0]    r_q;
   logic [N-1:0]  q_q, d_q, a_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  cociente_q, residuo_q;
   logic          div_cero_q;

   logic          load, shift, sub_en, count, corrige, done_w;
   logic          count_done, div_zero;
   estado_div_t   estado;
   logic [N:0]    trial;
   logic [N-1:0]  mag_a, mag_b, q_fin, r_fin;

`ifdef DIV_SIGNED_EN
   logic sa_q, sb_q;

   // |-2^(N-1)| wraps back to 2^(N-1), which is exact as an N-bit unsigned.
   assign mag_a = dividendo[N-1] ? -dividendo : dividendo;
   assign mag_b = divisor[N-1]   ? -divisor   : divisor;
   assign q_fin = (sa_q ^ sb_q) ? -q_q : q_q;
   assign r_fin = sa_q ? -r_q[N-1:0] : r_q[N-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa_q <= 1'b0;
         sb_q <= 1'b0;
      end else if (load) begin
         sa_q <= dividendo[N-1];
         sb_q <= divisor[N-1];
      end
   end
`else
   assign mag_a = dividendo;
   assign mag_b = divisor;
   assign q_fin = q_q;
   assign r_fin = r_q[N-1:0];
`endif

   assign trial      = r_q - {1'b0, d_q};
   assign count_done = (cnt_q == CW'(1));
   assign div_zero   = (d_q == '0);

   fsm_div u_fsm (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid),
      .count_done_i (count_done),
      .div_zero_i   (div_zero),
      .load_o       (load),
      .shift_o      (shift),
      .sub_en_o     (sub_en),
      .count_o      (count),
      .corrige_o    (corrige),
      .done_o       (done_w),
      .estado_o     (estado)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q   <= '0;
         q_q   <= '0;
         d_q   <= '0;
         a_q   <= '0;
         cnt_q <= '0;
      end else begin
         if (load) begin
            r_q   <= '0;
            q_q   <= mag_a;
            d_q   <= mag_b;
            a_q   <= dividendo;
            cnt_q <= CW'(N);
         end
         if (shift) begin
            r_q <= {r_q[N-1:0], q_q[N-1]};
            q_q <= {q_q[N-2:0], 1'b0};
         end
         if (sub_en) begin
            // Trial MSB clear means R >= D: keep the difference, quotient bit 1.
            if (!trial[N]) begin
               r_q    <= trial;
               q_q[0] <= 1'b1;
            end else begin
               q_q[0] <= 1'b0;
            end
         end
         if (count) cnt_q <= cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cociente_q <= '0;
         residuo_q  <= '0;
         div_cero_q <= 1'b0;
      end else if (corrige) begin
         if (div_zero) begin
            cociente_q <= '1;
            residuo_q  <= a_q;
            div_cero_q <= 1'b1;
         end else begin
            cociente_q <= q_fin;
            residuo_q  <= r_fin;
            div_cero_q <= 1'b0;
         end
      end
   end

   assign busy     = (estado != ESPERA_INICIO);
   assign done     = done_w;
   assign cociente = cociente_q;
   assign residuo  = residuo_q;
   assign div_cero = div_cero_q;

endmodule
